conv_window_gen: RTL and testbench

//  Forms the 3x3 pixel window for the conv2d3x3 datapath from a raster-order pixel stream.

---
 rtl/conv2d_pkg.sv | 20 ++
 rtl/conv_window_gen_row_delay.sv | 41 ++++
 rtl/conv_window_gen.sv | 141 ++++++++++++++
 tb/tb_conv_window_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared constants for the conv2d3x3 datapath: default image geometry and
// the slice order of the 3x3 window bus (slice 0 = top-left ... slice 8 = bottom-right).
package conv2d_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int IMG_WIDTH  = 100;
    localparam int IMG_HEIGHT = 100;
    localparam int WIN_TAPS   = 9;

    localparam int WIN_TL = 0;
    localparam int WIN_TM = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MM = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BM = 7;
    localparam int WIN_BR = 8;

endpackage

// File: rtl/conv_window_gen_row_delay.sv
// Enable-gated shift line of DEPTH stages; the last stage is the registered output,
// so a word written on one accepted cycle appears DEPTH accepted cycles later.
module row_delay #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] stage_d;

    // Shift one position per accepted pixel, otherwise hold.
    always_comb begin
        stage_d = stage_q;
        if (en_i) begin
            stage_d[0] = data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end else begin
            stage_d = stage_q;
        end
    end

    // Stage storage with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Builds the 3x3 window from a raster pixel stream: three 3-tap rows chained through
// two row delays, with column/row tracking that flags only fully populated windows.
module conv_window_gen
    import conv2d_pkg::*;
#(
    parameter int DATA_WIDTH = conv2d_pkg::DATA_WIDTH,
    parameter int IMG_WIDTH  = conv2d_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = conv2d_pkg::IMG_HEIGHT
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [DATA_WIDTH-1:0]          pixel_in,
    input  logic                           valid_in,
    input  logic                           sof_in,
    output logic [WIN_TAPS*DATA_WIDTH-1:0] win_out,
    output logic                           valid_out,
    output logic                           eof_out
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int DEPTH = IMG_WIDTH - 3;

    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    logic             emit, last_win;

    // Tap index 0 is the oldest column of each row; row0 is the oldest row.
    logic [2:0][DATA_WIDTH-1:0] row0_q, row0_d;
    logic [2:0][DATA_WIDTH-1:0] row1_q, row1_d;
    logic [2:0][DATA_WIDTH-1:0] row2_q, row2_d;
    logic [DATA_WIDTH-1:0]      mid_dly, top_dly;

    logic [WIN_TAPS*DATA_WIDTH-1:0] win_q, win_d;
    logic                           valid_q, valid_d;
    logic                           eof_q, eof_d;

    row_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_delay_mid (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .en_i   (valid_in),
        .data_i (row2_q[0]),
        .data_o (mid_dly)
    );

    row_delay #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_delay_top (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .en_i   (valid_in),
        .data_i (row1_q[0]),
        .data_o (top_dly)
    );

    // Position of the incoming pixel; sof forces it to (0,0) before classification.
    always_comb begin
        cur_col  = sof_in ? {COL_W{1'b0}} : col_q;
        cur_row  = sof_in ? {ROW_W{1'b0}} : row_q;
        col_d    = col_q;
        row_d    = row_q;
        emit     = 1'b0;
        last_win = 1'b0;
        if (valid_in) begin
            emit     = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            last_win = (cur_row == ROW_W'(IMG_HEIGHT-1)) && (cur_col == COL_W'(IMG_WIDTH-1));
            if (cur_col == COL_W'(IMG_WIDTH-1)) begin
                col_d = {COL_W{1'b0}};
                row_d = (cur_row == ROW_W'(IMG_HEIGHT-1)) ? {ROW_W{1'b0}} : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Tap shifting: each row takes its newest value from the row below it via the delays.
    always_comb begin
        row0_d = row0_q;
        row1_d = row1_q;
        row2_d = row2_q;
        if (valid_in) begin
            row0_d = {top_dly,  row0_q[2], row0_q[1]};
            row1_d = {mid_dly,  row1_q[2], row1_q[1]};
            row2_d = {pixel_in, row2_q[2], row2_q[1]};
        end else begin
            row0_d = row0_q;
            row1_d = row1_q;
            row2_d = row2_q;
        end
    end

    // Window is captured from the post-shift taps so it ends at the pixel just accepted.
    always_comb begin
        win_d   = win_q;
        valid_d = emit;
        eof_d   = emit && last_win;
        if (emit) begin
            win_d[WIN_TL*DATA_WIDTH +: DATA_WIDTH] = row0_d[0];
            win_d[WIN_TM*DATA_WIDTH +: DATA_WIDTH] = row0_d[1];
            win_d[WIN_TR*DATA_WIDTH +: DATA_WIDTH] = row0_d[2];
            win_d[WIN_ML*DATA_WIDTH +: DATA_WIDTH] = row1_d[0];
            win_d[WIN_MM*DATA_WIDTH +: DATA_WIDTH] = row1_d[1];
            win_d[WIN_MR*DATA_WIDTH +: DATA_WIDTH] = row1_d[2];
            win_d[WIN_BL*DATA_WIDTH +: DATA_WIDTH] = row2_d[0];
            win_d[WIN_BM*DATA_WIDTH +: DATA_WIDTH] = row2_d[1];
            win_d[WIN_BR*DATA_WIDTH +: DATA_WIDTH] = row2_d[2];
        end else begin
            win_d = win_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            col_q   <= {COL_W{1'b0}};
            row_q   <= {ROW_W{1'b0}};
            row0_q  <= '0;
            row1_q  <= '0;
            row2_q  <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            row2_q  <= row2_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
        end
    end

    assign win_out   = win_q;
    assign valid_out = valid_q;
    assign eof_out   = eof_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 6x5 image with pixel = row*16+col.
module tb_conv_window_gen;

    localparam int DW = 8;
    localparam int W  = 6;
    localparam int H  = 5;

    logic          Clk;
    logic          Rst;
    logic [DW-1:0] pixel_in;
    logic          valid_in;
    logic          sof_in;
    logic [9*DW-1:0] win_out;
    logic          valid_out;
    logic          eof_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    conv_window_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .sof_in    (sof_in),
        .win_out   (win_out),
        .valid_out (valid_out),
        .eof_out   (eof_out)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [DW-1:0] pix(input int r, input int c);
        return DW'(r * 16 + c);
    endfunction

    function automatic logic [9*DW-1:0] exp_win(input int r, input int c);
        logic [9*DW-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[k*DW +: DW] = pix(r - 2 + k / 3, c - 2 + k % 3);
        end
        return w;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] p);
        valid_in = v;
        sof_in   = s;
        pixel_in = p;
        @(posedge Clk);
        #1;
        valid_in = 1'b0;
        sof_in   = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0; pixel_in = '0;
        #1;
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_out); else pass_cnt++;
        total_cnt++; if (eof_out !== 1'b0) $display("FAIL reset_eof got=%b exp=0", eof_out); else pass_cnt++;
        total_cnt++; if (win_out !== '0) $display("FAIL reset_win got=%h exp=0", win_out); else pass_cnt++;
        @(posedge Clk); #1;
        Rst = 1'b0;
    endtask

    task automatic test_continuous();
        int wins, eofs, r, c;
        logic exp_v;
        logic [9*DW-1:0] first_win;
        first_win = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
        wins = 0; eofs = 0;
        for (int n = 0; n < W*H; n++) begin
            r = n / W; c = n % W;
            drive(1'b1, n == 0, pix(r, c));
            exp_v = (r >= 2) && (c >= 2);
            if (valid_out) wins++;
            total_cnt++; if (valid_out !== exp_v) $display("FAIL cont_valid px=%h got=%b exp=%b", pix(r, c), valid_out, exp_v); else pass_cnt++;
            if (exp_v) begin
                total_cnt++; if (win_out !== exp_win(r, c)) $display("FAIL cont_win px=%h got=%h exp=%h", pix(r, c), win_out, exp_win(r, c)); else pass_cnt++;
            end
            if (r == 2 && c == 2) begin
                total_cnt++; if (win_out !== first_win) $display("FAIL cont_first_win got=%h exp=%h", win_out, first_win); else pass_cnt++;
            end
            if (eof_out) begin
                eofs++;
                total_cnt++; if (pix(r, c) !== 8'h45) $display("FAIL cont_eof_pos got=%h exp=45", pix(r, c)); else pass_cnt++;
            end
        end
        total_cnt++; if (wins != 12) $display("FAIL cont_win_count got=%0d exp=12", wins); else pass_cnt++;
        total_cnt++; if (eofs != 1) $display("FAIL cont_eof_count got=%0d exp=1", eofs); else pass_cnt++;
    endtask

    task automatic test_gaps();
        int wins, eofs, r, c, gaps;
        logic exp_v, have_win;
        logic [9*DW-1:0] last_exp;
        wins = 0; eofs = 0; have_win = 1'b0; last_exp = '0;
        for (int n = 0; n < W*H; n++) begin
            r = n / W; c = n % W;
            drive(1'b1, n == 0, pix(r, c));
            exp_v = (r >= 2) && (c >= 2);
            if (valid_out) wins++;
            if (eof_out) eofs++;
            total_cnt++; if (valid_out !== exp_v) $display("FAIL gap_valid px=%h got=%b exp=%b", pix(r, c), valid_out, exp_v); else pass_cnt++;
            if (exp_v) begin
                last_exp = exp_win(r, c);
                have_win = 1'b1;
                total_cnt++; if (win_out !== last_exp) $display("FAIL gap_win px=%h got=%h exp=%h", pix(r, c), win_out, last_exp); else pass_cnt++;
            end
            gaps = (n % 2 == 0) ? 1 : int'($urandom_range(2, 0));
            for (int g = 0; g < gaps; g++) begin
                drive(1'b0, 1'b1, 8'hFF);
                total_cnt++; if (valid_out !== 1'b0 || eof_out !== 1'b0) $display("FAIL gap_idle_flags valid=%b eof=%b exp=0/0", valid_out, eof_out); else pass_cnt++;
                if (have_win) begin
                    total_cnt++; if (win_out !== last_exp) $display("FAIL gap_hold got=%h exp=%h", win_out, last_exp); else pass_cnt++;
                end
            end
        end
        total_cnt++; if (wins != 12) $display("FAIL gap_win_count got=%0d exp=12", wins); else pass_cnt++;
        total_cnt++; if (eofs != 1) $display("FAIL gap_eof_count got=%0d exp=1", eofs); else pass_cnt++;
    endtask

    task automatic test_row_boundary();
        int r, c;
        logic [9*DW-1:0] w32;
        w32 = {8'h32, 8'h31, 8'h30, 8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10};
        for (int n = 0; n < W*H; n++) begin
            r = n / W; c = n % W;
            drive(1'b1, n == 0, pix(r, c));
            if (r == 3 && c < 2) begin
                total_cnt++; if (valid_out !== 1'b0) $display("FAIL row_edge_valid px=%h got=%b exp=0", pix(r, c), valid_out); else pass_cnt++;
            end
            if (r == 3 && c == 2) begin
                total_cnt++; if (valid_out !== 1'b1) $display("FAIL row_edge_v32 got=%b exp=1", valid_out); else pass_cnt++;
                total_cnt++; if (win_out !== w32) $display("FAIL row_edge_w32 got=%h exp=%h", win_out, w32); else pass_cnt++;
            end
        end
    endtask

    task automatic test_sof_restart();
        int wins, eofs, r, c;
        logic exp_v;
        eofs = 0; wins = 0;
        // Abandoned frame carries bit 7 so any stale exposure shows in the window data.
        for (int n = 0; n < 2*W + 3; n++) begin
            drive(1'b1, n == 0, pix(n / W, n % W) | 8'h80);
            if (eof_out) eofs++;
        end
        for (int n = 0; n < W*H; n++) begin
            r = n / W; c = n % W;
            drive(1'b1, n == 0, pix(r, c));
            exp_v = (r >= 2) && (c >= 2);
            if (valid_out) wins++;
            if (eof_out) eofs++;
            total_cnt++; if (valid_out !== exp_v) $display("FAIL sof_valid px=%h got=%b exp=%b", pix(r, c), valid_out, exp_v); else pass_cnt++;
            if (exp_v) begin
                total_cnt++; if (win_out !== exp_win(r, c)) $display("FAIL sof_win px=%h got=%h exp=%h", pix(r, c), win_out, exp_win(r, c)); else pass_cnt++;
            end
        end
        total_cnt++; if (wins != 12) $display("FAIL sof_win_count got=%0d exp=12", wins); else pass_cnt++;
        total_cnt++; if (eofs != 1) $display("FAIL sof_eof_count got=%0d exp=1", eofs); else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        int wins, eofs, r, c;
        logic exp_v;
        wins = 0; eofs = 0;
        for (int n = 0; n <= 3*W + 4; n++) begin
            drive(1'b1, n == 0, pix(n / W, n % W));
        end
        total_cnt++; if (valid_out !== 1'b1) $display("FAIL rst_pre_valid got=%b exp=1", valid_out); else pass_cnt++;
        #3;
        Rst = 1'b1;
        #1;
        total_cnt++; if (valid_out !== 1'b0) $display("FAIL rst_mid_valid got=%b exp=0", valid_out); else pass_cnt++;
        total_cnt++; if (win_out !== '0) $display("FAIL rst_mid_win got=%h exp=0", win_out); else pass_cnt++;
        total_cnt++; if (eof_out !== 1'b0) $display("FAIL rst_mid_eof got=%b exp=0", eof_out); else pass_cnt++;
        #2;
        Rst = 1'b0;
        @(posedge Clk); #1;
        for (int n = 0; n < W*H; n++) begin
            r = n / W; c = n % W;
            drive(1'b1, 1'b0, pix(r, c));
            exp_v = (r >= 2) && (c >= 2);
            if (valid_out) wins++;
            if (eof_out) eofs++;
            if (exp_v) begin
                total_cnt++; if (win_out !== exp_win(r, c) || valid_out !== 1'b1) $display("FAIL rst_win px=%h got=%h/%b exp=%h/1", pix(r, c), win_out, valid_out, exp_win(r, c)); else pass_cnt++;
            end
        end
        total_cnt++; if (wins != 12) $display("FAIL rst_win_count got=%0d exp=12", wins); else pass_cnt++;
        total_cnt++; if (eofs != 1) $display("FAIL rst_eof_count got=%0d exp=1", eofs); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int wins, eofs, r, c;
        logic exp_v;
        wins = 0; eofs = 0;
        for (int n = 0; n < 2*W*H; n++) begin
            r = (n / W) % H; c = n % W;
            drive(1'b1, n == 0, pix(r, c));
            exp_v = (r >= 2) && (c >= 2);
            if (valid_out) wins++;
            total_cnt++; if (valid_out !== exp_v) $display("FAIL b2b_valid n=%0d got=%b exp=%b", n, valid_out, exp_v); else pass_cnt++;
            if (exp_v) begin
                total_cnt++; if (win_out !== exp_win(r, c)) $display("FAIL b2b_win n=%0d got=%h exp=%h", n, win_out, exp_win(r, c)); else pass_cnt++;
            end
            if (eof_out) begin
                eofs++;
                total_cnt++; if (pix(r, c) !== 8'h45) $display("FAIL b2b_eof_pos got=%h exp=45", pix(r, c)); else pass_cnt++;
            end
        end
        total_cnt++; if (wins != 24) $display("FAIL b2b_win_count got=%0d exp=24", wins); else pass_cnt++;
        total_cnt++; if (eofs != 2) $display("FAIL b2b_eof_count got=%0d exp=2", eofs); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_row_boundary();
        test_sof_restart();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
